// File: rtl/dcache_pkg.sv
// Shared widths, FSM state type and address field helpers for the data cache.
package dcache_pkg;

    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned INDEX_W  = 5;
    localparam int unsigned OFFSET_W = 2;
    localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int unsigned LINES    = 1 << INDEX_W;
    localparam int unsigned WORDS    = 1 << OFFSET_W;

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StWrite
    } state_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W-1:0];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the direct-mapped cache: asynchronous read, one-word
// synchronous write port, and a synchronous clear of every valid bit on rst.
module dcache_line_array
    import dcache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [INDEX_W-1:0]  rd_index,
    input  logic [OFFSET_W-1:0] rd_offset,
    output logic                rd_valid,
    output logic [TAG_W-1:0]    rd_tag,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                wr_en,
    input  logic [INDEX_W-1:0]  wr_index,
    input  logic [OFFSET_W-1:0] wr_offset,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                set_valid,
    input  logic                clr_valid,
    input  logic [TAG_W-1:0]    wr_tag
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES*WORDS];

    // Valid bits: reset wins, then line completion, then invalidation at refill start.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (set_valid) begin
            valid_q[wr_index] <= 1'b1;
        end else if (clr_valid) begin
            valid_q[wr_index] <= 1'b0;
        end
    end

    // Tag is written together with the valid bit when a refill completes.
    always_ff @(posedge clk) begin
        if (set_valid) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    // Data words carry no reset; a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache controller. Read hits are
// served combinationally; read misses refill a whole line in word order, stores are
// written through to backing memory while the core is stalled.
module dcache_controller
    import dcache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] WordAddress,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              stall,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned BASE_W = ADDR_W - OFFSET_W;

    state_t              state_q, state_d;
    logic [OFFSET_W-1:0] cnt_q, cnt_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [DATA_W-1:0]   dout_q;

    logic                arr_valid;
    logic [TAG_W-1:0]    arr_tag;
    logic [DATA_W-1:0]   arr_rdata;
    logic                arr_wr_en;
    logic [INDEX_W-1:0]  arr_wr_index;
    logic [OFFSET_W-1:0] arr_wr_offset;
    logic [DATA_W-1:0]   arr_wr_data;
    logic                arr_set_valid;
    logic                arr_clr_valid;
    logic [TAG_W-1:0]    arr_wr_tag;
    logic                hit;
    logic                rd_hit_now;

    dcache_line_array u_lines (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (get_index(WordAddress)),
        .rd_offset (get_offset(WordAddress)),
        .rd_valid  (arr_valid),
        .rd_tag    (arr_tag),
        .rd_data   (arr_rdata),
        .wr_en     (arr_wr_en & ~rst),
        .wr_index  (arr_wr_index),
        .wr_offset (arr_wr_offset),
        .wr_data   (arr_wr_data),
        .set_valid (arr_set_valid & ~rst),
        .clr_valid (arr_clr_valid & ~rst),
        .wr_tag    (arr_wr_tag)
    );

    assign hit = arr_valid && (arr_tag == get_tag(WordAddress));

    // State, refill counter, latched line base and held load data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            base_q  <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            dout_q  <= DataOut;
        end
    end

    // Next-state, memory-side requests, array write control and core-side outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        base_d        = base_q;
        stall         = 1'b0;
        mem_rd_req    = 1'b0;
        mem_wr_req    = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        arr_wr_en     = 1'b0;
        arr_wr_index  = get_index(WordAddress);
        arr_wr_offset = get_offset(WordAddress);
        arr_wr_data   = DataIn;
        arr_set_valid = 1'b0;
        arr_clr_valid = 1'b0;
        arr_wr_tag    = base_q[BASE_W-1 -: TAG_W];
        rd_hit_now    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (MemWrite) begin
                    stall   = 1'b1;
                    state_d = StWrite;
                end else if (MemRead) begin
                    if (hit) begin
                        rd_hit_now = 1'b1;
                    end else begin
                        stall         = 1'b1;
                        state_d       = StRefill;
                        cnt_d         = '0;
                        base_d        = WordAddress[ADDR_W-1:OFFSET_W];
                        // Line stays invalid until its last word lands, so an abort
                        // never leaves a half-filled line looking valid.
                        arr_clr_valid = 1'b1;
                    end
                end
            end
            StRefill: begin
                stall         = 1'b1;
                mem_rd_req    = 1'b1;
                mem_addr      = {base_q, cnt_q};
                arr_wr_index  = base_q[INDEX_W-1:0];
                arr_wr_offset = cnt_q;
                arr_wr_data   = mem_rdata;
                if (mem_ready) begin
                    arr_wr_en = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        arr_set_valid = 1'b1;
                        state_d       = StIdle;
                    end
                end
            end
            StWrite: begin
                mem_wr_req = 1'b1;
                mem_addr   = WordAddress;
                mem_wdata  = DataIn;
                // Core advances on the ack edge.
                stall      = ~mem_ready;
                if (mem_ready) begin
                    arr_wr_en = hit;
                    state_d   = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        DataOut = rd_hit_now ? arr_rdata : dout_q;
    end

endmodule
